// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller.
//   frame_state_e   : receive FSM states
//   DefaultSyncByte : default start-of-frame marker
//   DefaultMaxLen   : default maximum payload length in bytes
//   state_is_busy() : true while a frame is being collected
package uart_pkg;

   localparam logic [7:0]  DefaultSyncByte = 8'hA5;
   localparam int unsigned DefaultMaxLen   = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StPayload,
      StChk,
      StHold
   } frame_state_e;

   function automatic logic state_is_busy(input frame_state_e st);
      return (st == StLen) || (st == StPayload) || (st == StChk);
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: Depth x Width register file, one synchronous write port and
// one asynchronous read port. Contents are not reset; they persist until
// overwritten.
//   clk_i     : clock
//   wr_en_i   : write enable
//   wr_addr_i : write index
//   wr_data_i : write data
//   rd_addr_i : read index
//   rd_data_o : read data (combinational)
module uart_frame_buf
   import uart_pkg::*;
#(
   parameter int unsigned Depth = DefaultMaxLen,
   parameter int unsigned Width = 8
) (
   input  logic                     clk_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(Depth)-1:0] wr_addr_i,
   input  logic [Width-1:0]         wr_data_i,
   input  logic [$clog2(Depth)-1:0] rd_addr_i,
   output logic [Width-1:0]         rd_data_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Depth is a power of two, so every address is in range.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame receiver on top of a byte-level UART receiver.
// Frame: SYNC, LEN, LEN payload bytes, CHK; LEN + payload + CHK == 0 mod 256.
// A checked frame is held in the payload buffer until frame_ack_i.
//   clk_i          : clock
//   reset_i        : asynchronous active-high reset
//   rx_valid_i     : one-cycle strobe, new received byte
//   rx_byte_i      : received byte
//   frame_ack_i    : consumer releases the held frame
//   rd_addr_i      : payload read index
//   rd_data_o      : payload byte at rd_addr_i (combinational)
//   frame_valid_o  : a checked frame is held
//   frame_len_o    : payload length of held frame, 0 otherwise
//   err_chksum_o   : pulse, checksum mismatch
//   err_len_o      : pulse, length byte 0 or above MAX_LEN
//   err_timeout_o  : pulse, inter-byte timeout while collecting
//   overrun_o      : pulse, byte dropped while a frame is held
//   busy_o         : collecting a frame (LEN, PAYLOAD, CHK)
module uart_frame_ctrl
   import uart_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = DefaultSyncByte,
   parameter int unsigned MAX_LEN        = DefaultMaxLen,
   parameter int unsigned TIMEOUT_CYCLES = 208320
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       rx_valid_i,
   input  logic [7:0]                 rx_byte_i,
   input  logic                       frame_ack_i,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr_i,
   output logic [7:0]                 rd_data_o,
   output logic                       frame_valid_o,
   output logic [$clog2(MAX_LEN):0]   frame_len_o,
   output logic                       err_chksum_o,
   output logic                       err_len_o,
   output logic                       err_timeout_o,
   output logic                       overrun_o,
   output logic                       busy_o
);

   localparam int unsigned AddrW = $clog2(MAX_LEN);
   localparam int unsigned LenW  = AddrW + 1;
   localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);

   frame_state_e state_q, state_d;
   logic [LenW-1:0]  len_q, len_d;
   logic [AddrW-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic err_chksum_q, err_chksum_d;
   logic err_len_q, err_len_d;
   logic err_timeout_q, err_timeout_d;
   logic overrun_q, overrun_d;

   logic       wr_en;
   logic       len_ok;
   logic       last_payload;
   logic [7:0] sum_next;

   assign sum_next     = sum_q + rx_byte_i;
   assign len_ok       = (rx_byte_i != 8'd0) && ({1'b0, rx_byte_i} <= 9'(MAX_LEN));
   assign last_payload = ({1'b0, idx_q} == (len_q - LenW'(1)));

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      idx_d         = idx_q;
      sum_d         = sum_q;
      cnt_d         = cnt_q;
      wr_en         = 1'b0;
      err_chksum_d  = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      overrun_d     = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (rx_valid_i && (rx_byte_i == SYNC_BYTE)) begin
               state_d = StLen;
            end
         end

         StLen, StPayload, StChk: begin
            if (rx_valid_i) begin
               // A byte in the expiry cycle wins over the timeout.
               cnt_d = '0;
               case (state_q)
                  StLen: begin
                     if (len_ok) begin
                        len_d   = LenW'(rx_byte_i);
                        sum_d   = rx_byte_i;
                        idx_d   = '0;
                        state_d = StPayload;
                     end else begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                     end
                  end
                  StPayload: begin
                     wr_en = 1'b1;
                     sum_d = sum_next;
                     idx_d = idx_q + AddrW'(1);
                     if (last_payload) begin
                        state_d = StChk;
                     end
                  end
                  default: begin
                     if (sum_next == 8'h00) begin
                        state_d = StHold;
                     end else begin
                        err_chksum_d = 1'b1;
                        state_d      = StIdle;
                     end
                  end
               endcase
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               err_timeout_d = 1'b1;
               cnt_d         = '0;
               state_d       = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StHold: begin
            cnt_d = '0;
            if (rx_valid_i) begin
               overrun_d = 1'b1;
            end
            if (frame_ack_i) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         len_q         <= '0;
         idx_q         <= '0;
         sum_q         <= '0;
         cnt_q         <= '0;
         err_chksum_q  <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         cnt_q         <= cnt_d;
         err_chksum_q  <= err_chksum_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         overrun_q     <= overrun_d;
      end
   end

   uart_frame_buf #(
      .Depth (MAX_LEN),
      .Width (8)
   ) u_buf (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (idx_q),
      .wr_data_i (rx_byte_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

   assign frame_valid_o = (state_q == StHold);
   assign frame_len_o   = frame_valid_o ? len_q : '0;
   assign busy_o        = state_is_busy(state_q);
   assign err_chksum_o  = err_chksum_q;
   assign err_len_o     = err_len_q;
   assign err_timeout_o = err_timeout_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

   localparam int unsigned MaxLen = 16;
   localparam int unsigned To     = 40;
   localparam int unsigned AW     = $clog2(MaxLen);
   localparam int unsigned LW     = AW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          frame_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          frame_valid;
   logic [LW-1:0] frame_len;
   logic          err_chksum, err_len, err_timeout, overrun, busy;

   int errors = 0;
   int checks = 0;

   // Pulse tallies, sampled away from the active edge.
   int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

   uart_frame_ctrl #(
      .SYNC_BYTE      (8'hA5),
      .MAX_LEN        (MaxLen),
      .TIMEOUT_CYCLES (To)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .rx_valid_i    (rx_valid),
      .rx_byte_i     (rx_byte),
      .frame_ack_i   (frame_ack),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .frame_valid_o (frame_valid),
      .frame_len_o   (frame_len),
      .err_chksum_o  (err_chksum),
      .err_len_o     (err_len),
      .err_timeout_o (err_timeout),
      .overrun_o     (overrun),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_chksum)  n_chk++;
      if (err_len)     n_len++;
      if (err_timeout) n_to++;
      if (overrun)     n_ovr++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs change 1 time unit after the active edge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
   endtask

   task automatic test_reset();
      if (frame_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid);
      end
      checks++;
      if (frame_len !== '0) begin
         errors++; $display("FAIL reset_len: got %0d expected 0", frame_len);
      end
      checks++;
      if ({err_chksum, err_len, err_timeout, overrun, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000",
                            {err_chksum, err_len, err_timeout, overrun, busy});
      end
      checks++;
   endtask

   task automatic test_basic();
      logic [7:0] exp_data [3];
      int e0;
      exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
      e0 = n_chk + n_len + n_to + n_ovr;
      send_byte(8'hA5); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      if (busy !== 1'b1 || frame_valid !== 1'b0) begin
         errors++; $display("FAIL basic_before_chk: busy=%b valid=%b expected 1 0", busy, frame_valid);
      end
      checks++;
      send_byte(8'h97);
      if (frame_valid !== 1'b1) begin
         errors++; $display("FAIL basic_valid: got %b expected 1", frame_valid);
      end
      checks++;
      if (frame_len !== LW'(3)) begin
         errors++; $display("FAIL basic_len: got %0d expected 3", frame_len);
      end
      checks++;
      for (int i = 0; i < 3; i++) begin
         rd_addr = AW'(i);
         #1;
         if (rd_data !== exp_data[i]) begin
            errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, rd_data, exp_data[i]);
         end
         checks++;
      end
      pulse_ack();
      if (frame_valid !== 1'b0 || frame_len !== '0) begin
         errors++; $display("FAIL basic_ack: valid=%b len=%0d expected 0 0", frame_valid, frame_len);
      end
      checks++;
      rd_addr = AW'(1);
      #1;
      if (rd_data !== 8'h22) begin
         errors++; $display("FAIL basic_persist: got %h expected 22", rd_data);
      end
      checks++;
      if (n_chk + n_len + n_to + n_ovr !== e0) begin
         errors++; $display("FAIL basic_no_err: got %0d pulses expected 0", n_chk + n_len + n_to + n_ovr - e0);
      end
      checks++;
   endtask

   task automatic test_chksum();
      int c0;
      c0 = n_chk;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
      send_byte(8'h00);
      if (err_chksum !== 1'b1) begin
         errors++; $display("FAIL chksum_pulse_latency: got %b expected 1", err_chksum);
      end
      checks++;
      idle_cycles(3);
      if (n_chk - c0 !== 1) begin
         errors++; $display("FAIL chksum_count: got %0d expected 1", n_chk - c0);
      end
      checks++;
      if (frame_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL chksum_idle: valid=%b busy=%b expected 0 0", frame_valid, busy);
      end
      checks++;
   endtask

   task automatic test_len();
      int l0;
      l0 = n_len;
      send_byte(8'hA5); send_byte(8'h00);
      if (err_len !== 1'b1) begin
         errors++; $display("FAIL len_zero: got %b expected 1", err_len);
      end
      checks++;
      send_byte(8'hA5); send_byte(8'h11);
      if (err_len !== 1'b1) begin
         errors++; $display("FAIL len_17: got %b expected 1", err_len);
      end
      checks++;
      // MAX_LEN itself is legal: A5 10 + 16 zero bytes, chk = F0.
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'h00);
      send_byte(8'hF0);
      idle_cycles(1);
      if (n_len - l0 !== 2 || frame_valid !== 1'b1 || frame_len !== LW'(16)) begin
         errors++; $display("FAIL len_max: errs=%0d valid=%b len=%0d expected 2 1 16",
                            n_len - l0, frame_valid, frame_len);
      end
      checks++;
      pulse_ack();
   endtask

   task automatic test_timeout();
      int hit;
      int t0;
      t0  = n_to;
      hit = 0;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      for (int k = 1; k <= int'(To) + 5; k++) begin
         @(posedge clk);
         #1;
         if (err_timeout && hit == 0) hit = k;
      end
      if (hit !== int'(To)) begin
         errors++; $display("FAIL timeout_latency: got %0d expected %0d", hit, To);
      end
      checks++;
      if (n_to - t0 !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_count: got %0d busy=%b expected 1 0", n_to - t0, busy);
      end
      checks++;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
      if (frame_valid !== 1'b1) begin
         errors++; $display("FAIL timeout_recover: got %b expected 1", frame_valid);
      end
      checks++;
      pulse_ack();
   endtask

   // Each byte lands in the exact cycle the timeout would expire.
   task automatic test_timeout_race();
      int t0;
      t0 = n_to;
      send_byte(8'hA5);
      send_byte(8'h03);
      idle_cycles(To - 1); send_byte(8'h11);
      idle_cycles(To - 1); send_byte(8'h22);
      idle_cycles(To - 1); send_byte(8'h33);
      idle_cycles(To - 1); send_byte(8'h97);
      if (frame_valid !== 1'b1 || n_to - t0 !== 0) begin
         errors++; $display("FAIL timeout_race: valid=%b timeouts=%0d expected 1 0", frame_valid, n_to - t0);
      end
      checks++;
      pulse_ack();
   endtask

   task automatic test_overrun();
      int o0;
      o0 = n_ovr;
      // 02 + 5A + A5 + FF == 0; A5 inside the payload is data.
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5);
      send_byte(8'hFF);
      send_byte(8'hA5);
      if (overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_pulse: got %b expected 1", overrun);
      end
      checks++;
      send_byte(8'h02);
      idle_cycles(1);
      if (n_ovr - o0 !== 2 || frame_valid !== 1'b1 || frame_len !== LW'(2)) begin
         errors++; $display("FAIL overrun_two: ovr=%0d valid=%b len=%0d expected 2 1 2",
                            n_ovr - o0, frame_valid, frame_len);
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         rd_addr = AW'(i);
         #1;
         if (rd_data !== ((i == 0) ? 8'h5A : 8'hA5)) begin
            errors++; $display("FAIL overrun_data[%0d]: got %h", i, rd_data);
         end
         checks++;
      end
      frame_ack = 1'b1;
      send_byte(8'h33);
      frame_ack = 1'b0;
      if (overrun !== 1'b1 || frame_valid !== 1'b0) begin
         errors++; $display("FAIL overrun_ack_together: ovr=%b valid=%b expected 1 0", overrun, frame_valid);
      end
      checks++;
   endtask

   task automatic test_ack_ignored();
      pulse_ack();
      send_byte(8'hA5); send_byte(8'h01);
      pulse_ack();
      send_byte(8'h07); send_byte(8'hF8);
      if (frame_valid !== 1'b1 || frame_len !== LW'(1)) begin
         errors++; $display("FAIL ack_ignored: valid=%b len=%0d expected 1 1", frame_valid, frame_len);
      end
      checks++;
      pulse_ack();
   endtask

   task automatic test_mid_reset();
      int e0;
      e0 = n_chk + n_len + n_to + n_ovr;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      reset = 1'b1;
      #1;
      if ({frame_valid, busy, err_chksum, err_len, err_timeout, overrun} !== 6'b0 ||
          frame_len !== '0) begin
         errors++; $display("FAIL midreset_outputs: got %b len=%0d expected 0",
                            {frame_valid, busy, err_chksum, err_len, err_timeout, overrun}, frame_len);
      end
      checks++;
      idle_cycles(2);
      reset = 1'b0;
      idle_cycles(1);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
      rd_addr = '0;
      #1;
      if (frame_valid !== 1'b1 || frame_len !== LW'(1) || rd_data !== 8'h42) begin
         errors++; $display("FAIL midreset_frame: valid=%b len=%0d data=%h expected 1 1 42",
                            frame_valid, frame_len, rd_data);
      end
      checks++;
      if (n_chk + n_len + n_to + n_ovr !== e0) begin
         errors++; $display("FAIL midreset_no_err: got %0d pulses expected 0", n_chk + n_len + n_to + n_ovr - e0);
      end
      checks++;
      pulse_ack();
   endtask

   // Random frames; outcome predicted from the frame rules alone.
   task automatic test_random();
      logic [7:0] pl [MaxLen];
      logic [7:0] s, chk, b;
      int len, sel, c0, l0;
      bit corrupt;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h3C;
            idle_cycles($urandom_range(0, 3));
            send_byte(b);
         end
         sel = $urandom_range(0, 19);
         if (sel == 0)      len = 0;
         else if (sel == 1) len = int'(MaxLen) + 1 + $urandom_range(0, 200);
         else               len = $urandom_range(1, MaxLen);
         s = 8'(len);
         for (int i = 0; i < MaxLen; i++) pl[i] = 8'h00;
         for (int i = 0; i < len && i < int'(MaxLen); i++) begin
            pl[i] = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            s = s + pl[i];
         end
         chk = 8'h00 - s;
         corrupt = ($urandom_range(0, 3) == 0);
         if (corrupt) chk = chk + 8'($urandom_range(1, 255));
         c0 = n_chk;
         l0 = n_len;
         idle_cycles($urandom_range(0, 3)); send_byte(8'hA5);
         idle_cycles($urandom_range(0, 3)); send_byte(8'(len));
         if (len >= 1 && len <= int'(MaxLen)) begin
            for (int i = 0; i < len; i++) begin
               idle_cycles($urandom_range(0, 3));
               send_byte(pl[i]);
            end
            idle_cycles($urandom_range(0, 3));
            send_byte(chk);
         end
         idle_cycles(1);
         if (len < 1 || len > int'(MaxLen)) begin
            if (n_len - l0 !== 1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
               errors++; $display("FAIL rand_len[%0d]: errs=%0d valid=%b busy=%b len=%0d",
                                  f, n_len - l0, frame_valid, busy, len);
            end
            checks++;
         end else if (corrupt) begin
            if (n_chk - c0 !== 1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
               errors++; $display("FAIL rand_chk[%0d]: errs=%0d valid=%b busy=%b",
                                  f, n_chk - c0, frame_valid, busy);
            end
            checks++;
         end else begin
            if (frame_valid !== 1'b1 || frame_len !== LW'(len)) begin
               errors++; $display("FAIL rand_frame[%0d]: valid=%b len=%0d expected 1 %0d",
                                  f, frame_valid, frame_len, len);
            end
            checks++;
            for (int i = 0; i < len; i++) begin
               rd_addr = AW'(i);
               #1;
               if (rd_data !== pl[i]) begin
                  errors++; $display("FAIL rand_data[%0d][%0d]: got %h expected %h", f, i, rd_data, pl[i]);
               end
               checks++;
            end
            pulse_ack();
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      frame_ack = 1'b0;
      rd_addr   = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      idle_cycles(1);
      test_basic();
      test_chksum();
      test_len();
      test_timeout();
      test_timeout_race();
      test_overrun();
      test_ack_ignored();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the start-of-frame marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, the maximum payload length in bytes (power of two, 2..256).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 208320, the inter-byte timeout in clk_i cycles (20 bit-times at 9600 baud / 100 MHz).
REQ-004 SHALL have port clk_i  input  1  single clock domain.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe from the UART receiver marking a new byte.
REQ-007 SHALL have port rx_byte_i  input  8  received byte, sampled when rx_valid_i=1.
REQ-008 SHALL have port frame_ack_i  input  1  consumer releases the held frame.
REQ-009 SHALL have port rd_addr_i  input  $clog2(MAX_LEN)  payload buffer read index.
REQ-010 SHALL have port rd_data_o  output  8  payload byte at rd_addr_i (combinational read).
REQ-011 SHALL have port frame_valid_o  output  1  a checked frame is held in the buffer.
REQ-012 SHALL have port frame_len_o  output  $clog2(MAX_LEN)+1  payload length of the held frame.
REQ-013 SHALL have port err_chksum_o, err_len_o, err_timeout_o, overrun_o  output  1 each  one-cycle error pulses.
REQ-014 SHALL have port busy_o  output  1  high in states LEN, PAYLOAD and CHK.

Function
REQ-015 Frame format SHALL be SYNC, LEN, LEN payload bytes, CHK; the 8-bit sum of LEN, the payload bytes and CHK SHALL equal 8'h00 mod 256.
REQ-016 States SHALL be IDLE, LEN, PAYLOAD, CHK and HOLD; only rx_valid_i cycles advance the state, except for timeout and ack.
REQ-017 IDLE: on a byte equal to SYNC_BYTE go to LEN; other bytes SHALL be discarded silently.
REQ-018 LEN: a byte of 0 or a byte greater than MAX_LEN SHALL pulse err_len_o and return to IDLE; otherwise latch the length, seed the running sum with it, clear the write index and go to PAYLOAD.
REQ-019 PAYLOAD: each byte SHALL be written to buffer[index], added to the sum, and the index incremented; after the LEN-th byte go to CHK.
REQ-020 CHK: if sum+byte == 0 go to HOLD; otherwise pulse err_chksum_o and return to IDLE, with the buffer contents undefined-valid (not exposed).
REQ-021 HOLD: frame_valid_o=1 and frame_len_o=latched LEN; rx bytes in HOLD SHALL be dropped, each pulsing overrun_o; frame_ack_i=1 SHALL return to IDLE the next cycle.
REQ-022 Latency: frame_valid_o SHALL rise the cycle after the CHK byte's rx_valid_i cycle; each error pulse SHALL assert the cycle after its causing event.
REQ-023 Timeout counter SHALL clear on every accepted rx_valid_i and in IDLE/HOLD; in LEN/PAYLOAD/CHK, reaching TIMEOUT_CYCLES SHALL pulse err_timeout_o and return to IDLE.
REQ-024 A byte arriving in the same cycle the timeout expires SHALL win: the byte is processed and no timeout is reported.
REQ-025 frame_ack_i SHALL be ignored outside HOLD; frame_ack_i together with rx_valid_i in HOLD SHALL drop the byte (overrun_o pulses) and still exit to IDLE.
REQ-026 A SYNC_BYTE value inside LEN, PAYLOAD or CHK SHALL be treated as data, not as a resync.
REQ-027 frame_len_o SHALL read 0 whenever frame_valid_o=0; buffer contents SHALL persist until overwritten by the next frame's payload.

Reset
REQ-028 On reset_i: state=IDLE; frame_valid_o=0; frame_len_o=0; all error pulses=0; busy_o=0; the index, sum and timeout counter=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without any error pulse; buffer contents need not be cleared.

Structure
REQ-030 A shared package uart_pkg SHALL hold the frame state enum typedef and the default SYNC_BYTE and MAX_LEN constants.
REQ-031 The payload store SHALL be a sub-module uart_frame_buf: a MAX_LEN x 8 register file with one write port and an asynchronous read port.

Verification
REQ-032 Send A5 03 11 22 33 97 -> frame_valid_o=1 one cycle after 97, frame_len_o=3, rd_data_o at addresses 0/1/2 = 11/22/33.
REQ-033 Send A5 02 10 20 00 -> err_chksum_o pulses once, frame_valid_o stays 0, state returns to IDLE.
REQ-034 Send A5 00, then A5 11 -> err_len_o pulses for each frame (length 0 and 17 with MAX_LEN=16).
REQ-035 Send A5 03 11 with no further bytes -> err_timeout_o pulses exactly TIMEOUT_CYCLES cycles after the 11 byte; a following valid frame is accepted.
REQ-036 Send a valid frame, then 2 bytes while it is unacknowledged -> overrun_o pulses twice and the buffer is unchanged; frame_ack_i -> frame_valid_o=0 next cycle.
REQ-037 Assert reset_i after A5 03 11 -> all outputs return to 0 immediately, and a subsequent A5 01 42 BD produces frame_valid_o with frame_len_o=1 and rd_data_o[0]=42.
